read_aligner: RTL and testbench
===============================

READ_ALIGNER -- requirements
Module: read_aligner

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning SRAM word width in bits (power of two, 2..64).
REQ-002 SHALL have parameter DEPTH, default 3, meaning output buffer entries (min 2).
REQ-003 SHALL derive localparams AW = log2(DATA_W) and CONF_W = log2(AW+1) rounded up (3 for DATA_W=32).
REQ-004 SHALL have port clk input 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n input 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port req_valid input 1, meaning a read request is presented to the SRAM this cycle.
REQ-007 SHALL have port req_ready output 1, meaning the block can accept a request.
REQ-008 SHALL have port req_conf input CONF_W, meaning the aspect mode k; slice width W = DATA_W>>k.
REQ-009 SHALL have port req_addr input AW, meaning the low address bits selecting the slice.
REQ-010 SHALL have port req_fill input 1, meaning 0 zero-extends the slice and 1 replicates it across DATA_W.
REQ-011 SHALL have port sram_dout input DATA_W, meaning macro read data, valid exactly 1 cycle after accept.
REQ-012 SHALL have port out_valid output 1, meaning aligned data is available.
REQ-013 SHALL have port out_ready input 1, meaning the consumer takes data.
REQ-014 SHALL have port out_data output DATA_W, meaning the aligned word.
REQ-015 SHALL have port out_err output 1, meaning the accompanying entry had an illegal conf.

Function
REQ-016 SHALL accept a request when req_valid & req_ready, latching conf, addr low bits and fill into an in-flight register.
REQ-017 SHALL drive req_ready = (count + inflight) < DEPTH, with no combinational path from out_ready to req_ready.
REQ-018 SHALL, in the cycle after accept, capture sram_dout, extract the slice, and push {data, err} into the FIFO unconditionally; no push is ever dropped.
REQ-019 SHALL use slice index i = addr & ((1<<k)-1) and slice = sram_dout[i*W +: W] for k = 0..AW.
REQ-020 SHALL output the slice replicated DATA_W/W times when fill=1, and zero-extended when fill=0; k=0 passes the word unchanged.
REQ-021 SHALL, for k > AW, push sram_dout unchanged with err=1.
REQ-022 SHALL present the FIFO head on out_data/out_err with out_valid = (count != 0); pop on out_valid & out_ready.
REQ-023 SHALL handle simultaneous push and pop in one cycle, leaving count unchanged and preserving order.
REQ-024 SHALL have an accept-to-out_valid latency of 2 cycles into an empty FIFO.
REQ-025 SHALL sustain 1 request/cycle with out_ready held high and DEPTH >= 3.
REQ-026 SHALL hold out_data/out_err stable while out_valid=1 and out_ready=0.
REQ-027 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-028 SHALL, while rst_n=0, clear inflight, count, and pointers; out_valid=0, out_data=0, out_err=0, req_ready=0.
REQ-029 SHALL discard any in-flight request or buffered data on reset mid-operation, with no push in the cycle after rst_n deasserts.
REQ-030 SHALL assert req_ready in the first clock after rst_n deasserts.

Structure
REQ-031 SHALL place the conf encoding constants (CONF_X32=0 .. CONF_X1=5) and the slice-extract function in the shared sram package.
REQ-032 SHALL implement the FIFO as sub-module aligner_fifo (parametrised WIDTH, DEPTH); extraction and credit logic live in read_aligner.

Verification
REQ-033 SHALL verify: conf=2, addr=3, fill=1, sram_dout=0xA1B2C3D4 -> out_data=0xA1A1A1A1, err=0, 2 cycles after accept.
REQ-034 SHALL verify: conf=5, addr=31, fill=0, sram_dout=0x80000000 -> out_data=0x00000001; with fill=1 -> 0xFFFFFFFF.
REQ-035 SHALL verify: conf=6, sram_dout=0x12345678 -> out_data=0x12345678, out_err=1.
REQ-036 SHALL verify: 3 back-to-back requests with out_ready=0 -> req_ready=0 after the third accept; releasing out_ready drains 3 entries in order, then req_ready=1.
REQ-037 SHALL verify: 100 random requests with out_ready=1 -> one accept per cycle, outputs match the model in order.
REQ-038 SHALL verify: rst_n pulsed low with 2 entries buffered and 1 in flight -> out_valid=0 next cycle, no stale output after release.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared SRAM definitions: aspect-mode encodings and the slice extractor
// used to narrow a macro read word down to the addressed slice.
package sram_pkg;

    localparam int CONF_X32 = 0;
    localparam int CONF_X16 = 1;
    localparam int CONF_X8  = 2;
    localparam int CONF_X4  = 3;
    localparam int CONF_X2  = 4;
    localparam int CONF_X1  = 5;

    // Slice width is dw>>k; the slice is either zero-extended or tiled across dw.
    function automatic logic [63:0] extract_slice(input logic [63:0] word, input int dw,
                                                  input int k, input int addr, input logic fill);
        logic [63:0] res;
        int          w;
        int          base;
        int          idx;
        logic [5:0]  src;
        res  = '0;
        w    = dw >> k;
        base = (addr & ((1 << k) - 1)) * w;
        for (int b = 0; b < 64; b++) begin
            idx = fill ? (b & (w - 1)) : b;
            src = 6'(base + idx);
            if (b < dw && (fill || b < w))
                res[b] = word[src];
        end
        return res;
    endfunction

endpackage

// File: rtl/aligner_fifo.sv
// Small circular output buffer; the caller guarantees no push when full
// and no pop when empty.
module aligner_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= nxt(wr_ptr);
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/read_aligner.sv
// Aligns SRAM read data to the requested aspect ratio; credit-based request
// acceptance guarantees the one-cycle-later push always has room.
module read_aligner
    import sram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 3,
    localparam int AW     = $clog2(DATA_W),
    localparam int CONF_W = $clog2(AW + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CONF_W-1:0] req_conf,
    input  logic [AW-1:0]     req_addr,
    input  logic              req_fill,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic              inflight;
    logic [CONF_W-1:0] if_conf;
    logic [AW-1:0]     if_addr;
    logic              if_fill;
    logic              push_err;
    logic [DATA_W-1:0] push_word;
    logic [DATA_W:0]   head;
    logic [CW-1:0]     count;
    logic [CW:0]       occ;
    logic              accept;
    logic              pop;

    // Occupancy counts the in-flight read, so the FIFO never sees a push it cannot hold.
    assign occ       = (CW+1)'(count) + (CW+1)'(inflight);
    assign req_ready = rst_n && (occ < (CW+1)'(DEPTH));
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            if_conf  <= '0;
            if_addr  <= '0;
            if_fill  <= 1'b0;
        end else begin
            inflight <= accept;
            if (accept) begin
                if_conf <= req_conf;
                if_addr <= req_addr;
                if_fill <= req_fill;
            end
        end
    end

    always_comb begin
        push_err  = int'(if_conf) > AW;
        push_word = push_err ? sram_dout
                  : DATA_W'(extract_slice(64'(sram_dout), DATA_W, int'(if_conf),
                                          int'(if_addr), if_fill));
    end

    aligner_fifo #(.WIDTH(DATA_W + 1), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data ({push_err, push_word}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
    assign out_err   = out_valid && head[DATA_W];

endmodule

// File: tb/tb_read_aligner.sv
// Scoreboard bench for read_aligner: the driver queues expected words on
// accept, a negedge monitor pops and compares whenever data is taken.
module tb_read_aligner;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 3;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_conf;
    logic [4:0]  req_addr;
    logic        req_fill;
    logic [31:0] sram_dout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_d;
    logic        hold_e;

    read_aligner #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_conf  (req_conf),
        .req_addr  (req_addr),
        .req_fill  (req_fill),
        .sram_dout (sram_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference by shift-and-mask on the whole word.
    function automatic exp_t model(input logic [2:0] k, input logic [4:0] a,
                                   input logic f, input logic [31:0] word);
        exp_t        e;
        int          w;
        int          i;
        logic [31:0] mask;
        logic [31:0] s;
        logic [31:0] r;
        if (k > 3'd5) begin
            e.data = word;
            e.err  = 1'b1;
            return e;
        end
        w    = 32 >> k;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        i    = int'(a) & ((1 << k) - 1);
        s    = (word >> (i * w)) & mask;
        r    = s;
        if (f)
            for (int j = 1; j < 32 / w; j++)
                r = r | (s << (j * w));
        e.data = r;
        e.err  = 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && hold_prev) begin
            check("hold_data", 64'(out_data), 64'(hold_d));
            check("hold_err", 64'(out_err), 64'(hold_e));
        end
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %0h expected none", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", 64'(out_data), 64'(mon_e.data));
                check("out_err", 64'(out_err), 64'(mon_e.err));
            end
        end
        hold_prev = rst_n && out_valid && !out_ready;
        hold_d    = out_data;
        hold_e    = out_err;
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic issue(input logic [2:0] c, input logic [4:0] a, input logic f,
                         input logic [31:0] w, input logic [31:0] ed, input logic ee,
                         output int stalls);
        exp_t e;
        bit   acc;
        int   n;
        req_conf  = c;
        req_addr  = a;
        req_fill  = f;
        req_valid = 1'b1;
        e.data    = ed;
        e.err     = ee;
        acc       = 1'b0;
        n         = 0;
        stalls    = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sram_dout = w;
                exp_q.push_back(e);
            end else begin
                sram_dout = $urandom;
                stalls++;
            end
            n++;
        end
        req_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            sram_dout = $urandom;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          st;
        int          tot;
        int          n;
        exp_t        e;
        logic [2:0]  c;
        logic [4:0]  a;
        logic        f;
        logic [31:0] w;

        rst_n = 1'b0; req_valid = 1'b0; req_conf = '0; req_addr = '0;
        req_fill = 1'b0; sram_dout = '0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_err", 64'(out_err), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(req_ready), 64'(1));
        @(posedge clk); #1;

        // Byte slice replicated; latency check.
        issue(3'd2, 5'd3, 1'b1, 32'hA1B2C3D4, 32'hA1A1A1A1, 1'b0, st);
        @(negedge clk);
        check("lat_cycle1_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("lat_cycle2_valid", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        cycles(2);

        // Directed patterns, back to back.
        issue(3'd5, 5'd31, 1'b0, 32'h80000000, 32'h00000001, 1'b0, st);
        issue(3'd5, 5'd31, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, st);
        issue(3'd6, 5'd0,  1'b0, 32'h12345678, 32'h12345678, 1'b1, st);
        issue(3'd0, 5'd9,  1'b1, 32'hA1B2C3D4, 32'hA1B2C3D4, 1'b0, st);
        issue(3'd1, 5'd1,  1'b0, 32'hA1B2C3D4, 32'h0000A1B2, 1'b0, st);
        issue(3'd3, 5'd2,  1'b1, 32'hA1B2C3D4, 32'h33333333, 1'b0, st);
        issue(3'd4, 5'd7,  1'b0, 32'hA1B2C3D4, 32'h00000003, 1'b0, st);
        issue(3'd2, 5'd7,  1'b0, 32'hA1B2C3D4, 32'h000000A1, 1'b0, st);
        issue(3'd7, 5'd5,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, st);
        cycles(4);

        // Backpressure: three accepts fill the credits.
        out_ready = 1'b0;
        issue(3'd2, 5'd0, 1'b0, 32'h11223344, 32'h00000044, 1'b0, st);
        issue(3'd2, 5'd1, 1'b0, 32'h11223344, 32'h00000033, 1'b0, st);
        issue(3'd2, 5'd2, 1'b0, 32'h11223344, 32'h00000022, 1'b0, st);
        @(negedge clk);
        check("full_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        cycles(2);
        @(negedge clk);
        check("full_req_ready_hold", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        check("drain_req_ready", 64'(req_ready), 64'(1));
        @(posedge clk); #1;

        // Streaming with out_ready high: no stalls allowed.
        tot = 0;
        for (int i = 0; i < 100; i++) begin
            c = 3'($urandom_range(0, 7));
            a = 5'($urandom);
            f = 1'($urandom);
            w = $urandom;
            e = model(c, a, f, w);
            issue(c, a, f, w, e.data, e.err, st);
            tot += st;
        end
        check("stream_stalls", 64'(tot), 64'(0));
        cycles(5);
        check("stream_left", 64'(exp_q.size()), 64'(0));

        // Reset with two buffered and one in flight.
        out_ready = 1'b0;
        issue(3'd0, 5'd0, 1'b0, 32'hCAFE0001, 32'hCAFE0001, 1'b0, st);
        issue(3'd0, 5'd0, 1'b0, 32'hCAFE0002, 32'hCAFE0002, 1'b0, st);
        issue(3'd0, 5'd0, 1'b0, 32'hCAFE0003, 32'hCAFE0003, 1'b0, st);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_out_data", 64'(out_data), 64'(0));
        check("midrst_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(req_ready), 64'(1));
        check("post_rst_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("post_rst_valid2", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        cycles(3);
        issue(3'd1, 5'd0, 1'b1, 32'h5A5A1234, 32'h12341234, 1'b0, st);
        cycles(4);
        check("final_left", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
